sd_init_sequencer: RTL

Card-identification sequencer that drives the SD command engine through the power-up and initialisation flow, with no software involvement. Order: power-up wait, CMD0, CMD8, CMD55/ACMD41 poll, CMD2, CMD3, CMD7, optional ACMD6, CMD16. It sits between the Wishbone register front-end and the command controller, and owns the command-request lines until init completes. It exports RCA, card capacity class, bus-width status and an SD-clock speed select.

---
 rtl/sd_ctrl_pkg.sv | 55 +++++
 rtl/sd_init_timer.sv | 26 ++
 rtl/sd_init_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sd_ctrl_pkg.sv
// Shared definitions for the SD card-identification sequencer:
// FSM states, command indices, error codes and fixed command arguments.
package sd_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWERUP,
    ST_CMD0,
    ST_CMD8,
    ST_CMD55,
    ST_ACMD41,
    ST_POLL,
    ST_CMD2,
    ST_CMD3,
    ST_CMD7,
    ST_CMD55_BW,
    ST_ACMD6,
    ST_CMD16,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [3:0] {
    ERR_NONE             = 4'd0,
    ERR_CMD8_ECHO        = 4'd1,
    ERR_ACMD41_EXHAUSTED = 4'd2,
    ERR_TIMEOUT          = 4'd3,
    ERR_RESP_INDEX       = 4'd4
  } err_t;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD2   = 6'd2;
  localparam logic [5:0] CMD3   = 6'd3;
  localparam logic [5:0] CMD7   = 6'd7;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD16  = 6'd16;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD6  = 6'd6;
  localparam logic [5:0] ACMD41 = 6'd41;

  // R2 and R3 responses carry the reserved index 63 instead of the command index
  localparam logic [5:0] RESP_IDX_R2R3 = 6'd63;

  localparam logic [31:0] CMD8_PATTERN     = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_ARG_HCS   = 32'h40FF_8000;
  localparam logic [31:0] ACMD41_ARG_SCS   = 32'h00FF_8000;
  localparam logic [31:0] ACMD6_ARG_4BIT   = 32'd2;
  localparam logic [31:0] CMD16_ARG_BLKLEN = 32'd512;

  // Response index a command must come back with
  function automatic logic [5:0] expected_resp_index(input logic [5:0] idx);
    return (idx == CMD2 || idx == ACMD41) ? RESP_IDX_R2R3 : idx;
  endfunction

endpackage

// File: rtl/sd_init_timer.sv
// Loadable 32-bit down-counter used for the power-up idle and ACMD41 poll gap.
// expired is suppressed in the load cycle so a stale zero never ends a fresh wait.
module sd_init_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expired
);

  logic [31:0] count;

  // Load on request, otherwise count down and stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == '0) && !load;

endmodule

// File: rtl/sd_init_sequencer.sv
// SD card-identification sequencer: power-up wait, CMD0, CMD8, CMD55/ACMD41
// polling, CMD2, CMD3, CMD7, optional CMD55/ACMD6, CMD16.
// Optional 4-bit bus switch enabled by defining SD_INIT_4BIT_EN.
module sd_init_sequencer
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 48000,
  parameter int unsigned ACMD41_RETRIES = 1000,
  parameter int unsigned POLL_GAP       = 48000
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start,
  output logic        cmd_start,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic [5:0]  resp_index,
  input  logic [31:0] resp_arg,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  error_code,
  output logic [15:0] rca,
  output logic        card_hc,
  output logic        fast_clk_sel,
  output logic        bus_4bit
);

  state_t      state;
  state_t      next_state;
  err_t        fail;
  logic        waiting;
  logic        v2;
  logic [31:0] attempts;
  logic [31:0] attempts_inc;
  logic        timer_load;
  logic [31:0] timer_value;
  logic        timer_expired;
  logic [5:0]  issue_index;
  logic [31:0] issue_arg;
  logic        unused_resp_bits;

  assign unused_resp_bits = ^resp_arg[15:8];
  assign attempts_inc     = (attempts == '1) ? attempts : attempts + 32'd1;

  sd_init_timer u_timer (
    .clk     (wb_clk),
    .rst_n   (wb_rst),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  // Command index and argument for the command state being issued
  always_comb begin
    issue_index = CMD0;
    issue_arg   = '0;
    case (state)
      ST_CMD8:     begin issue_index = CMD8;   issue_arg = CMD8_PATTERN; end
      ST_CMD55,
      ST_CMD55_BW: begin issue_index = CMD55;  issue_arg = {rca, 16'h0}; end
      ST_ACMD41:   begin issue_index = ACMD41; issue_arg = v2 ? ACMD41_ARG_HCS : ACMD41_ARG_SCS; end
      ST_CMD2:     issue_index = CMD2;
      ST_CMD3:     issue_index = CMD3;
      ST_CMD7:     begin issue_index = CMD7;   issue_arg = {rca, 16'h0}; end
      ST_ACMD6:    begin issue_index = ACMD6;  issue_arg = ACMD6_ARG_4BIT; end
      ST_CMD16:    begin issue_index = CMD16;  issue_arg = CMD16_ARG_BLKLEN; end
      default:     ;
    endcase
  end

  // Outcome of a completed command: error classification and successor state
  always_comb begin
    fail       = ERR_NONE;
    next_state = state;
    if (cmd_timeout && state != ST_CMD0 && state != ST_CMD8)
      fail = ERR_TIMEOUT;
    else if (!cmd_timeout && state != ST_CMD0 && resp_index != expected_resp_index(cmd_index))
      fail = ERR_RESP_INDEX;
    else if (state == ST_CMD8 && !cmd_timeout && resp_arg[7:0] != CMD8_PATTERN[7:0])
      fail = ERR_CMD8_ECHO;
    else if (state == ST_ACMD41 && !resp_arg[31] && attempts_inc == 32'(ACMD41_RETRIES))
      fail = ERR_ACMD41_EXHAUSTED;
    case (state)
      ST_CMD0:     next_state = ST_CMD8;
      ST_CMD8:     next_state = ST_CMD55;
      ST_CMD55:    next_state = ST_ACMD41;
      ST_ACMD41:   next_state = resp_arg[31] ? ST_CMD2 : ST_POLL;
      ST_CMD2:     next_state = ST_CMD3;
      ST_CMD3:     next_state = ST_CMD7;
`ifdef SD_INIT_4BIT_EN
      ST_CMD7:     next_state = ST_CMD55_BW;
      ST_CMD55_BW: next_state = ST_ACMD6;
      ST_ACMD6:    next_state = ST_CMD16;
`else
      ST_CMD7:     next_state = ST_CMD16;
`endif
      ST_CMD16:    next_state = ST_DONE;
      default:     ;
    endcase
  end

  // Main sequencer: issue/wait handshake per command, waits, result capture
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state        <= ST_IDLE;
      waiting      <= 1'b0;
      v2           <= 1'b0;
      attempts     <= '0;
      timer_load   <= 1'b0;
      timer_value  <= '0;
      cmd_start    <= 1'b0;
      cmd_index    <= '0;
      cmd_arg      <= '0;
      init_busy    <= 1'b0;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
      error_code   <= '0;
      rca          <= '0;
      card_hc      <= 1'b0;
      fast_clk_sel <= 1'b0;
      bus_4bit     <= 1'b0;
    end else begin
      cmd_start  <= 1'b0;
      timer_load <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state        <= ST_POWERUP;
            waiting      <= 1'b0;
            v2           <= 1'b0;
            attempts     <= '0;
            timer_load   <= 1'b1;
            timer_value  <= 32'(POWERUP_CYCLES);
            init_busy    <= 1'b1;
            init_done    <= 1'b0;
            init_error   <= 1'b0;
            error_code   <= '0;
            rca          <= '0;
            card_hc      <= 1'b0;
            fast_clk_sel <= 1'b0;
            bus_4bit     <= 1'b0;
          end
        end
        ST_POWERUP: if (timer_expired) state <= ST_CMD0;
        ST_POLL:    if (timer_expired) state <= ST_CMD55;
        default: begin
          if (!waiting) begin
            if (!cmd_busy) begin
              cmd_start <= 1'b1;
              cmd_index <= issue_index;
              cmd_arg   <= issue_arg;
              waiting   <= 1'b1;
            end
          end else if (cmd_done) begin
            waiting <= 1'b0;
            if (fail != ERR_NONE) begin
              state      <= ST_ERROR;
              error_code <= fail;
              init_busy  <= 1'b0;
              init_error <= 1'b1;
            end else begin
              state <= next_state;
              case (state)
                ST_CMD8: v2 <= !cmd_timeout;
                ST_ACMD41: begin
                  if (resp_arg[31]) begin
                    card_hc <= resp_arg[30];
                  end else begin
                    attempts    <= attempts_inc;
                    timer_load  <= 1'b1;
                    timer_value <= 32'(POLL_GAP);
                  end
                end
                ST_CMD3: rca <= resp_arg[31:16];
`ifdef SD_INIT_4BIT_EN
                ST_ACMD6: bus_4bit <= 1'b1;
`endif
                ST_CMD16: begin
                  fast_clk_sel <= 1'b1;
                  init_busy    <= 1'b0;
                  init_done    <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
